// File: rtl/crc_stream_engine.sv
// crc_stream_engine: streaming MSB-first CRC encoder/checker with a
// valid/ready word input and a valid/ready result output.
module crc_stream_engine #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned CRC_W  = 3,
  parameter int unsigned CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CRC_W:0]    poly,
  input  logic              chk,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  input  logic              in_last,
  output logic              in_ready,
  input  logic [CRC_W-1:0]  crc_in,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [CRC_W-1:0]  crc_out,
  output logic              err,
  output logic [CNT_W-1:0]  len_out
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e             state_q, state_d;
  logic [CRC_W-1:0]   rem_q, rem_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CRC_W-1:0]   poly_q, poly_d;
  logic               chk_q, chk_d;
  logic [CRC_W-1:0]   crc_out_q, crc_out_d;
  logic               err_q, err_d;
  logic [CNT_W-1:0]   len_q, len_d;
  logic               res_valid_q, res_valid_d;
  logic               in_ready_q, in_ready_d;

  logic               beat;
  logic               first;
  logic               mode;
  logic [CRC_W-1:0]   step_poly;
  logic [CRC_W-1:0]   rem_next;
  logic [CNT_W-1:0]   cnt_next;

  // The x^CRC_W term of the generator is implied and never read.
  logic unused_poly_msb;
  assign unused_poly_msb = poly[CRC_W];

  // Shift one data word through the remainder, MSB first.
  function automatic logic [CRC_W-1:0] crc_step(input logic [CRC_W-1:0]  rem,
                                                input logic [CRC_W-1:0]  p,
                                                input logic [DATA_W-1:0] d);
    logic [CRC_W-1:0] r;
    logic             fb;
    r = rem;
    for (int i = int'(DATA_W) - 1; i >= 0; i--) begin
      fb = r[CRC_W-1] ^ d[i];
      r  = r << 1;
      if (fb) r = r ^ p;
    end
    return r;
  endfunction

  // Next-state, datapath and registered-output computation.
  always_comb begin
    state_d     = state_q;
    rem_d       = rem_q;
    cnt_d       = cnt_q;
    poly_d      = poly_q;
    chk_d       = chk_q;
    crc_out_d   = crc_out_q;
    err_d       = err_q;
    len_d       = len_q;
    res_valid_d = res_valid_q;
    in_ready_d  = in_ready_q;

    beat      = in_valid && in_ready_q;
    first     = (state_q == IDLE);
    step_poly = first ? poly[CRC_W-1:0] : poly_q;
    mode      = first ? chk : chk_q;
    rem_next  = crc_step(first ? '0 : rem_q, step_poly, in_data);
    if (first)             cnt_next = CNT_W'(1);
    else if (cnt_q == '1)  cnt_next = cnt_q;
    else                   cnt_next = cnt_q + CNT_W'(1);

    unique case (state_q)
      IDLE, RUN: begin
        if (beat) begin
          rem_d  = rem_next;
          cnt_d  = cnt_next;
          poly_d = step_poly;
          chk_d  = mode;
          if (in_last) begin
            state_d     = DONE;
            crc_out_d   = rem_next;
            err_d       = mode && (rem_next != crc_in);
            len_d       = cnt_next;
            res_valid_d = 1'b1;
            in_ready_d  = 1'b0;
          end else begin
            state_d = RUN;
          end
        end
      end
      DONE: begin
        if (res_ready) begin
          state_d     = IDLE;
          res_valid_d = 1'b0;
          in_ready_d  = 1'b1;
        end
      end
      default: begin
        state_d     = IDLE;
        res_valid_d = 1'b0;
        in_ready_d  = 1'b1;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      rem_q       <= '0;
      cnt_q       <= '0;
      poly_q      <= '0;
      chk_q       <= 1'b0;
      crc_out_q   <= '0;
      err_q       <= 1'b0;
      len_q       <= '0;
      res_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      cnt_q       <= cnt_d;
      poly_q      <= poly_d;
      chk_q       <= chk_d;
      crc_out_q   <= crc_out_d;
      err_q       <= err_d;
      len_q       <= len_d;
      res_valid_q <= res_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign res_valid = res_valid_q;
  assign crc_out   = crc_out_q;
  assign err       = err_q;
  assign len_out   = len_q;

endmodule

// File: tb/tb_crc_stream_engine.sv
// Scoreboard bench for crc_stream_engine with directed, hand-computed vectors.
module tb_crc_stream_engine;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned CRC_W  = 3;
  localparam int unsigned CNT_W  = 8;

  typedef struct packed {
    logic [CRC_W-1:0] crc;
    logic             err;
    logic [CNT_W-1:0] len;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst;
  logic [CRC_W:0]    poly;
  logic              chk;
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_last;
  logic [CRC_W-1:0]  crc_in;
  logic              res_ready;

  logic              in_ready, res_valid, err;
  logic [CRC_W-1:0]  crc_out;
  logic [CNT_W-1:0]  len_out;

  logic              in_ready2, res_valid2, err2;
  logic [CRC_W-1:0]  crc_out2;
  logic [1:0]        len_out2;

  int   n_checks = 0;
  int   n_errors = 0;
  exp_t sb_q[$];

  logic             hold_prev = 1'b0;
  logic [CRC_W-1:0] prev_crc;
  logic             prev_err;
  logic [CNT_W-1:0] prev_len;
  exp_t             e;

  crc_stream_engine #(.DATA_W(DATA_W), .CRC_W(CRC_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .poly(poly), .chk(chk), .in_data(in_data),
    .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
    .crc_in(crc_in), .res_valid(res_valid), .res_ready(res_ready),
    .crc_out(crc_out), .err(err), .len_out(len_out)
  );

  crc_stream_engine #(.DATA_W(DATA_W), .CRC_W(CRC_W), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .poly(poly), .chk(chk), .in_data(in_data),
    .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready2),
    .crc_in(crc_in), .res_valid(res_valid2), .res_ready(res_ready),
    .crc_out(crc_out2), .err(err2), .len_out(len_out2)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic [CRC_W-1:0] c, input logic ev, input logic [CNT_W-1:0] l);
    exp_t x;
    x.crc = c; x.err = ev; x.len = l;
    sb_q.push_back(x);
  endtask

  task automatic send(input logic [DATA_W-1:0] d, input logic l, input logic [CRC_W-1:0] c);
    check("beat_in_ready", 32'(in_ready), 32'd1);
    in_data = d; in_last = l; crc_in = c; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Result must appear one cycle after the last beat and retire on the next edge.
  task automatic post_last();
    check("lat_res_valid", 32'(res_valid), 32'd1);
    check("done_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    check("idle_in_ready", 32'(in_ready), 32'd1);
    check("idle_res_valid", 32'(res_valid), 32'd0);
  endtask

  task automatic check_reset_state();
    check("rst_res_valid", 32'(res_valid), 32'd0);
    check("rst_crc_out", 32'(crc_out), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_len_out", 32'(len_out), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
  endtask

  initial begin
    rst = 1'b1; poly = 4'b1011; chk = 1'b0; in_data = '0;
    in_valid = 1'b0; in_last = 1'b0; crc_in = '0; res_ready = 1'b1;

    fork
      // Monitor: pop expectations on handshakes, verify hold stability.
      forever begin
        @(negedge clk);
        if (rst) begin
          hold_prev = 1'b0;
        end else begin
          if (hold_prev) begin
            check("hold_res_valid", 32'(res_valid), 32'd1);
            check("hold_crc_out", 32'(crc_out), 32'(prev_crc));
            check("hold_err", 32'(err), 32'(prev_err));
            check("hold_len_out", 32'(len_out), 32'(prev_len));
            check("hold_in_ready", 32'(in_ready), 32'd0);
          end
          if (res_valid && res_ready) begin
            if (sb_q.size() == 0) begin
              check("unexpected_result", 32'd1, 32'd0);
            end else begin
              e = sb_q.pop_front();
              check("sb_crc_out", 32'(crc_out), 32'(e.crc));
              check("sb_err", 32'(err), 32'(e.err));
              check("sb_len_out", 32'(len_out), 32'(e.len));
            end
          end
          hold_prev = res_valid && !res_ready;
          prev_crc  = crc_out;
          prev_err  = err;
          prev_len  = len_out;
        end
      end
      begin
        #200000;
        $display("FAIL watchdog: timeout, %0d checks, %0d errors", n_checks, n_errors);
        $fatal(1, "watchdog");
      end
    join_none

    idle(2);
    check_reset_state();
    rst = 1'b0;

    // Single word D3, poly 1011 -> 011.
    push(3'b011, 1'b0, 8'd1);
    send(8'hD3, 1'b1, 3'b000);
    post_last();

    // 00 then D3 with two bubbles -> 011, length 2.
    push(3'b011, 1'b0, 8'd2);
    send(8'h00, 1'b0, 3'b000);
    idle(2);
    send(8'hD3, 1'b1, 3'b000);
    post_last();

    // Check mode: matching and mismatching received CRC.
    chk = 1'b1;
    push(3'b011, 1'b0, 8'd1);
    send(8'hD3, 1'b1, 3'b011);
    post_last();
    push(3'b011, 1'b1, 8'd1);
    send(8'hD3, 1'b1, 3'b010);
    post_last();

    // 80,00 poly 1011 -> x^18 mod g = 110; crc_in only sampled on last beat,
    // poly/chk changes mid-message ignored.
    chk = 1'b1; poly = 4'b1011;
    push(3'b110, 1'b0, 8'd2);
    send(8'h80, 1'b0, 3'b000);
    poly = 4'b1101; chk = 1'b0;
    send(8'h00, 1'b1, 3'b110);
    post_last();
    chk = 1'b1; poly = 4'b1011;
    push(3'b110, 1'b1, 8'd2);
    send(8'h80, 1'b0, 3'b110);
    poly = 4'b1101; chk = 1'b0;
    send(8'h00, 1'b1, 3'b000);
    post_last();

    // Other polynomial: 80 with poly 1101 -> 101.
    poly = 4'b1101; chk = 1'b0;
    push(3'b101, 1'b0, 8'd1);
    send(8'h80, 1'b1, 3'b000);
    post_last();

    // Backpressure: result held three cycles, input ignored meanwhile.
    poly = 4'b1011;
    res_ready = 1'b0;
    push(3'b011, 1'b0, 8'd1);
    send(8'hD3, 1'b1, 3'b000);
    check("bp_res_valid", 32'(res_valid), 32'd1);
    in_data = 8'hFF; in_last = 1'b1; in_valid = 1'b1;
    idle(3);
    res_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
    check("bp_idle_in_ready", 32'(in_ready), 32'd1);
    check("bp_idle_res_valid", 32'(res_valid), 32'd0);

    // Reset mid-message, with a simultaneous last beat that must be dropped.
    send(8'h80, 1'b0, 3'b000);
    send(8'h00, 1'b0, 3'b000);
    rst = 1'b1; in_data = 8'hD3; in_last = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    check_reset_state();
    idle(1);
    check("rst_drop_res_valid", 32'(res_valid), 32'd0);
    push(3'b011, 1'b0, 8'd1);
    send(8'hD3, 1'b1, 3'b000);
    post_last();

    // Five-word message: full counter 5, 2-bit counter saturates at 3.
    push(3'b011, 1'b0, 8'd5);
    for (int i = 0; i < 4; i++) send(8'h00, 1'b0, 3'b000);
    send(8'hD3, 1'b1, 3'b000);
    check("sat_res_valid", 32'(res_valid2), 32'd1);
    check("sat_in_ready", 32'(in_ready2), 32'd0);
    check("sat_len_out", 32'(len_out2), 32'd3);
    check("sat_crc_out", 32'(crc_out2), 32'(3'b011));
    check("sat_err", 32'(err2), 32'd0);
    post_last();

    idle(3);
    check("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/crc_stream_engine.md
CRC_STREAM_ENGINE -- requirements
Module: crc_stream_engine

Interface
REQ-001 SHALL have parameter DATA_W, default 8, message word width in bits (>=1).
REQ-002 SHALL have parameter CRC_W, default 3, CRC remainder width in bits (1..DATA_W).
REQ-003 SHALL have parameter CNT_W, default 8, width of the message word counter.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port poly  input  CRC_W+1  generator polynomial, MSB is the x^CRC_W term (ignored, implied 1).
REQ-007 SHALL have port chk  input  1  mode: 0 = encode, 1 = check.
REQ-008 SHALL have port in_data  input  DATA_W  message word, MSB first-transmitted.
REQ-009 SHALL have port in_valid  input  1  in_data valid.
REQ-010 SHALL have port in_last  input  1  marks final word of message.
REQ-011 SHALL have port in_ready  output  1  engine accepts a word this cycle.
REQ-012 SHALL have port crc_in  input  CRC_W  received CRC, used in check mode.
REQ-013 SHALL have port res_valid  output  1  result outputs valid.
REQ-014 SHALL have port res_ready  input  1  consumer accepts result.
REQ-015 SHALL have port crc_out  output  CRC_W  computed remainder.
REQ-016 SHALL have port err  output  1  check-mode mismatch flag.
REQ-017 SHALL have port len_out  output  CNT_W  number of words in message.

Function
REQ-018 SHALL compute the remainder of (message bits * x^CRC_W) mod poly: zero initial value, no reflection, no final XOR, word bits processed MSB first, words in acceptance order.
REQ-019 SHALL accept a word on any cycle with in_valid=1 and in_ready=1 (a beat); at most one word per cycle, full throughput.
REQ-020 SHALL implement FSM IDLE, RUN, DONE; IDLE/RUN drive in_ready=1, DONE drives in_ready=0.
REQ-021 SHALL, in IDLE on a beat, sample poly and chk into registers, set running remainder to step(0, in_data), set word count 1, go to DONE if in_last else RUN.
REQ-022 SHALL, in RUN on a beat, update remainder = step(remainder, in_data), increment count, go to DONE if in_last.
REQ-023 SHALL ignore poly and chk changes after the first beat until the next message.
REQ-024 SHALL sample crc_in on the in_last beat only.
REQ-025 SHALL hold all state when in_valid=0 (bubbles allowed at any point of a message).
REQ-026 SHALL assert res_valid in DONE, starting the cycle after the in_last beat (latency 1 cycle).
REQ-027 SHALL hold crc_out, err, len_out, res_valid stable while res_valid=1 and res_ready=0.
REQ-028 SHALL return to IDLE on the cycle res_valid=1 and res_ready=1; in_valid in that cycle is not accepted (one-cycle bubble between messages).
REQ-029 SHALL drive err = (crc_out != registered crc_in) when chk=1, err = 0 when chk=0.
REQ-030 SHALL saturate the word count at 2^CNT_W-1 without wrapping.
REQ-031 SHALL treat a single beat with in_last=1 in IDLE as a complete one-word message.

Reset
REQ-032 SHALL on rst=1 at a clock edge enter IDLE, clear remainder, count, crc_out, err, len_out, res_valid to 0, regardless of state.
REQ-033 SHALL discard any in-progress message or unconsumed result on reset; in_ready=1 the first cycle after reset deasserts.
REQ-034 SHALL give rst priority over any simultaneous beat or result handshake.

Verification
REQ-035 SHALL verify: DATA_W=8, CRC_W=3, poly=4'b1011, chk=0, single beat 8'hD3 last -> next cycle res_valid=1, crc_out=3'b011, len_out=1, err=0.
REQ-036 SHALL verify: two beats 8'h00 then 8'hD3 (last), with 2 idle cycles between -> crc_out=3'b011, len_out=2.
REQ-037 SHALL verify: chk=1, beat 8'hD3 last with crc_in=3'b011 -> err=0; repeat with crc_in=3'b010 -> err=1, crc_out=3'b011.
REQ-038 SHALL verify: res_ready held 0 for 3 cycles after result -> outputs stable, in_ready=0, in_valid ignored; res_ready=1 -> IDLE next cycle.
REQ-039 SHALL verify: rst asserted after first beat of a 3-word message -> all outputs 0, in_ready=1; fresh 8'hD3 message then yields crc_out=3'b011, len_out=1.
REQ-040 SHALL verify: CNT_W=2, 5-word message -> len_out=3 (saturated).
